// File: rtl/mc_ctrl_pkg.sv
// Shared state codes, opcode/funct constants and ALU operation codes for the
// multi-cycle controller.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_FETCH  = 4'd0,
    ST_DECODE = 4'd1,
    ST_MEMADR = 4'd2,
    ST_MEMRD  = 4'd3,
    ST_MEMWB  = 4'd4,
    ST_MEMWR  = 4'd5,
    ST_EXEC   = 4'd6,
    ST_ALUWB  = 4'd7,
    ST_BRANCH = 4'd8,
    ST_ADDIEX = 4'd9,
    ST_ADDIWB = 4'd10,
    ST_JUMP   = 4'd11,
    ST_ERR    = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // States that wait on mem_rdy and are covered by the timeout counter.
  function automatic logic isWaitState(input state_t s);
    return (s == ST_FETCH) || (s == ST_MEMRD) || (s == ST_MEMWR);
  endfunction

endpackage

// File: rtl/mc_ctrl_if.sv
// Controller <-> datapath bundle: instruction fields and memory handshake in,
// datapath strobes, mux selects and status out.
interface mc_ctrl_if #(
  parameter int ALU_CTRL_W = 3
);

  logic [5:0]            op;
  logic [5:0]            funct;
  logic                  zero;
  logic                  mem_rdy;

  logic                  mem_req;
  logic                  mem_wr;
  logic                  iord;
  logic                  ir_wr;
  logic                  pc_wr;
  logic                  reg_w;
  logic                  reg_dst;
  logic                  mem2reg;
  logic                  alu_src_a;
  logic [1:0]            alu_src_b;
  logic [1:0]            pc_src;
  logic [ALU_CTRL_W-1:0] alu_ctrl;
  logic [3:0]            state_o;
  logic                  err;
  logic                  instr_done;

  modport master (
    input  op, funct, zero, mem_rdy,
    output mem_req, mem_wr, iord, ir_wr, pc_wr, reg_w, reg_dst, mem2reg,
           alu_src_a, alu_src_b, pc_src, alu_ctrl, state_o, err, instr_done
  );

  modport slave (
    output op, funct, zero, mem_rdy,
    input  mem_req, mem_wr, iord, ir_wr, pc_wr, reg_w, reg_dst, mem2reg,
           alu_src_a, alu_src_b, pc_src, alu_ctrl, state_o, err, instr_done
  );

endinterface

// File: rtl/mc_alu_dec.sv
// R-type funct to ALU operation decode, purely combinational; flags any funct
// without an ALU mapping so the controller can fault instead of writing back.
module mc_alu_dec
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] funct,
  output logic [2:0] aluOp,
  output logic       illegal
);

  always_comb begin
    aluOp   = ALU_ADD;
    illegal = 1'b0;
    case (funct)
      FN_ADD:  aluOp = ALU_ADD;
      FN_SUB:  aluOp = ALU_SUB;
      FN_AND:  aluOp = ALU_AND;
      FN_OR:   aluOp = ALU_OR;
      FN_SLT:  aluOp = ALU_SLT;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle Moore controller; LW 5 / SW, R, ADDI 4 / BEQ, J 3 cycles at zero wait,
// memory states stall on mem_rdy with a TIMEOUT fault. MC_CTRL_BNE_EN adds BNE.
module mc_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter int TIMEOUT    = 15,
  parameter int ALU_CTRL_W = 3
) (
  input  logic      clk,
  input  logic      rst_n,
  mc_ctrl_if.master bus
);

  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LIMIT = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

  state_t           state;
  state_t           stateNext;
  logic [CNT_W-1:0] waitCnt;
  logic             timeoutHit;
  logic             isStore;
  logic             branchTaken;
  logic [2:0]       decOp;
  logic             decIllegal;
  logic [2:0]       aluSel;

  mc_alu_dec uAluDec (
    .funct   (bus.funct),
    .aluOp   (decOp),
    .illegal (decIllegal)
  );

  // Fault on the cycle the count would reach TIMEOUT; a same-cycle mem_rdy wins.
  assign timeoutHit = (TIMEOUT != 0) && !bus.mem_rdy && (waitCnt == LIMIT);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_FETCH;
    end else begin
      state <= stateNext;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      waitCnt <= '0;
    end else if (stateNext != state) begin
      waitCnt <= '0;
    end else if (isWaitState(state) && !bus.mem_rdy && (TIMEOUT != 0)) begin
      waitCnt <= waitCnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      isStore <= 1'b0;
    end else if (state == ST_DECODE) begin
      isStore <= (bus.op == OP_SW);
    end
  end

`ifdef MC_CTRL_BNE_EN
  logic isBne;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      isBne <= 1'b0;
    end else if (state == ST_DECODE) begin
      isBne <= (bus.op == OP_BNE);
    end
  end

  assign branchTaken = bus.zero ^ isBne;
`else
  assign branchTaken = bus.zero;
`endif

  always_comb begin
    stateNext = ST_ERR;
    case (state)
      ST_FETCH: begin
        if (bus.mem_rdy)     stateNext = ST_DECODE;
        else if (timeoutHit) stateNext = ST_ERR;
        else                 stateNext = ST_FETCH;
      end
      ST_DECODE: begin
        case (bus.op)
          OP_LW, OP_SW: stateNext = ST_MEMADR;
          OP_RTYPE:     stateNext = ST_EXEC;
          OP_BEQ:       stateNext = ST_BRANCH;
`ifdef MC_CTRL_BNE_EN
          OP_BNE:       stateNext = ST_BRANCH;
`endif
          OP_ADDI:      stateNext = ST_ADDIEX;
          OP_J:         stateNext = ST_JUMP;
          default:      stateNext = ST_ERR;
        endcase
      end
      ST_MEMADR: stateNext = isStore ? ST_MEMWR : ST_MEMRD;
      ST_MEMRD: begin
        if (bus.mem_rdy)     stateNext = ST_MEMWB;
        else if (timeoutHit) stateNext = ST_ERR;
        else                 stateNext = ST_MEMRD;
      end
      ST_MEMWR: begin
        if (bus.mem_rdy)     stateNext = ST_FETCH;
        else if (timeoutHit) stateNext = ST_ERR;
        else                 stateNext = ST_MEMWR;
      end
      ST_EXEC:   stateNext = decIllegal ? ST_ERR : ST_ALUWB;
      ST_ADDIEX: stateNext = ST_ADDIWB;
      ST_MEMWB, ST_ALUWB, ST_ADDIWB, ST_BRANCH, ST_JUMP: stateNext = ST_FETCH;
      ST_ERR:    stateNext = ST_ERR;
      default:   stateNext = ST_ERR;
    endcase
  end

  always_comb begin
    bus.mem_req    = 1'b0;
    bus.mem_wr     = 1'b0;
    bus.iord       = 1'b0;
    bus.ir_wr      = 1'b0;
    bus.pc_wr      = 1'b0;
    bus.reg_w      = 1'b0;
    bus.reg_dst    = 1'b0;
    bus.mem2reg    = 1'b0;
    bus.alu_src_a  = 1'b0;
    bus.alu_src_b  = 2'b00;
    bus.pc_src     = 2'b00;
    bus.err        = 1'b0;
    bus.instr_done = 1'b0;
    aluSel         = ALU_ADD;
    case (state)
      ST_FETCH: begin
        bus.mem_req   = 1'b1;
        bus.alu_src_b = 2'b01;
        bus.ir_wr     = bus.mem_rdy;
        bus.pc_wr     = bus.mem_rdy;
      end
      ST_DECODE: bus.alu_src_b = 2'b11;
      ST_MEMADR, ST_ADDIEX: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 2'b10;
      end
      ST_MEMRD: begin
        bus.mem_req = 1'b1;
        bus.iord    = 1'b1;
      end
      ST_MEMWR: begin
        bus.mem_req    = 1'b1;
        bus.mem_wr     = 1'b1;
        bus.iord       = 1'b1;
        bus.instr_done = bus.mem_rdy;
      end
      ST_MEMWB: begin
        bus.reg_w      = 1'b1;
        bus.mem2reg    = 1'b1;
        bus.instr_done = 1'b1;
      end
      ST_EXEC: begin
        bus.alu_src_a = 1'b1;
        aluSel        = decOp;
      end
      ST_ALUWB: begin
        bus.reg_w      = 1'b1;
        bus.reg_dst    = 1'b1;
        bus.instr_done = 1'b1;
      end
      ST_ADDIWB: begin
        bus.reg_w      = 1'b1;
        bus.instr_done = 1'b1;
      end
      ST_BRANCH: begin
        bus.alu_src_a  = 1'b1;
        aluSel         = ALU_SUB;
        bus.pc_src     = 2'b01;
        bus.pc_wr      = branchTaken;
        bus.instr_done = 1'b1;
      end
      ST_JUMP: begin
        bus.pc_src     = 2'b10;
        bus.pc_wr      = 1'b1;
        bus.instr_done = 1'b1;
      end
      ST_ERR:  bus.err = 1'b1;
      default: ;
    endcase
  end

  // Wider ALU control buses carry the 3-bit op in the low bits, upper bits zero.
  always_comb begin
    bus.alu_ctrl      = '0;
    bus.alu_ctrl[2:0] = aluSel;
  end

  assign bus.state_o = state;

endmodule

// File: doc/mc_ctrl.md
MC_CTRL -- requirements
Module: mc_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 15, meaning: max memory-wait cycles before fault; 0 disables the timeout.
REQ-002 Parameter ALU_CTRL_W, default 3, meaning: ALU control width; legal values >=3, upper bits zero-extended.
REQ-003 clk  in  1  rising-edge clock, single domain.
REQ-004 rst_n  in  1  reset, synchronous, active-low.
REQ-005 op  in  6  opcode from instruction register, sampled in DECODE.
REQ-006 funct  in  6  function field, sampled in EXEC.
REQ-007 zero  in  1  ALU zero flag, sampled in BRANCH.
REQ-008 mem_rdy  in  1  memory completes request this cycle.
REQ-009 mem_req, mem_wr, iord, ir_wr, pc_wr, reg_w, reg_dst, mem2reg, alu_src_a  out  1 each  datapath strobes/selects.
REQ-010 alu_src_b  out  2, pc_src  out  2  datapath mux selects.
REQ-011 alu_ctrl  out  ALU_CTRL_W  ALU operation code.
REQ-012 state_o  out  4  current state code; err  out  1  sticky fault; instr_done  out  1  one-cycle pulse on last cycle of each instruction.

Function
REQ-013 Moore FSM, states/codes: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, ALUWB 7, BRANCH 8, ADDIEX 9, ADDIWB 10, JUMP 11, ERR 12; unused codes go to ERR.
REQ-014 Transitions: FETCH->DECODE on mem_rdy; DECODE by op: 100011/101011->MEMADR, 000000->EXEC, 000100->BRANCH, 001000->ADDIEX, 000010->JUMP, other->ERR; MEMADR->MEMRD (LW) or MEMWR (SW); MEMRD->MEMWB on mem_rdy; MEMWR->FETCH on mem_rdy; EXEC->ALUWB; ADDIEX->ADDIWB; MEMWB, ALUWB, ADDIWB, BRANCH, JUMP->FETCH; ERR holds until reset.
REQ-015 Zero-wait latencies: LW 5, SW 4, R-type 4, ADDI 4, BEQ 3, J 3 cycles.
REQ-016 Outputs default 0, alu_ctrl default add (010); per state: FETCH mem_req, alu_src_b=01, ir_wr and pc_wr only when mem_rdy; DECODE alu_src_b=11; MEMADR/ADDIEX alu_src_a=1, alu_src_b=10; MEMRD mem_req, iord; MEMWR mem_req, mem_wr, iord; MEMWB reg_w, mem2reg; EXEC alu_src_a=1, alu_ctrl from funct; ALUWB reg_w, reg_dst; ADDIWB reg_w; BRANCH alu_src_a=1, alu_ctrl sub (110), pc_src=01, pc_wr=zero; JUMP pc_src=10, pc_wr=1; ERR err=1 only.
REQ-017 EXEC funct map: 100000 add 010, 100010 sub 110, 100100 and 000, 100101 or 001, 101010 slt 111; any other funct -> next state ERR, ALUWB skipped.
REQ-018 Wait counter clears on entry to FETCH/MEMRD/MEMWR, increments each cycle mem_rdy=0 there; reaching TIMEOUT with mem_rdy=0 -> ERR; mem_rdy in the same cycle as the limit wins (normal transition).
REQ-019 mem_rdy outside FETCH/MEMRD/MEMWR is ignored.
REQ-020 instr_done asserts in MEMWB, ALUWB, ADDIWB, BRANCH, JUMP and on MEMWR completion cycle.

Reset
REQ-021 rst_n=0 at a clock edge: state FETCH, wait counter 0, err 0; outputs then follow FETCH decode (mem_req=1).
REQ-022 Reset mid-instruction or in ERR aborts immediately; no partial write strobes in the reset cycle's successor.

Configuration
REQ-023 Macro MC_CTRL_BNE_EN: defined -> op 000101 enters BRANCH with pc_wr=!zero; undefined -> 000101 goes to ERR.

Structure
REQ-024 Package mc_ctrl_pkg holds state codes, opcode/funct constants, ALU op codes.
REQ-025 Sub-module mc_alu_dec: combinational funct-to-alu_ctrl decode with illegal flag.

Verification
REQ-026 Reset then LW (op 100011), mem_rdy=1 always -> states 0,1,2,3,4, reg_w+mem2reg in cycle 5, instr_done once.
REQ-027 R-type funct 100010 -> alu_ctrl=110 in EXEC, reg_w+reg_dst in ALUWB; funct 000111 -> ERR, err=1 until rst_n=0.
REQ-028 BEQ with zero=1 -> pc_wr=1, pc_src=01 in BRANCH; zero=0 -> pc_wr=0.
REQ-029 FETCH with mem_rdy low 3 cycles -> ir_wr/pc_wr only on 4th cycle; low 15 cycles (TIMEOUT=15) -> ERR.
REQ-030 op 000101 -> BRANCH with pc_wr=!zero when MC_CTRL_BNE_EN defined, ERR otherwise.
REQ-031 rst_n low during MEMWR wait -> FETCH next cycle, mem_wr=0.
